// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit.
// Owns the HI/LO registers. Each MULT/MULTU/DIV/DIVU computes its result at
// the issue edge into pending registers. A busy counter then holds the result
// back for a fixed latency before it lands in HI/LO. MTHI/MTLO write in a
// single cycle. MFHI/MFLO read through MD_out.
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU
// (ops 9-12). These accumulate onto the HI/LO value present at the issue edge.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Interrupt,
  input  logic [3:0]  md_op,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out,
  output logic [31:0] MD_out
);

  localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        pend_hi_q, pend_hi_d;
  logic [31:0]        pend_lo_q, pend_lo_d;
  logic               pend_wr_q, pend_wr_d;

  // Arithmetic datapath signals
  logic signed [63:0] a_sx_s, b_sx_s;
  logic [63:0]        prod_s_s;
  logic [63:0]        prod_u_s;
`ifdef MDU_MADD_EN
  logic [63:0]        acc_s;
`endif
  logic [31:0]        div_b_s;
  logic [31:0]        a_mag_s, b_mag_s;
  logic [31:0]        sq_mag_s, sr_mag_s;
  logic [31:0]        sq_s, sr_s;
  logic [31:0]        uq_s, ur_s;

  // Decoded issue information for the op in E
  logic               op_valid_s;
  logic               res_wr_s;
  logic [31:0]        res_hi_s, res_lo_s;
  logic [CNT_W-1:0]   res_cycles_s;
  logic               issue_s;

  // Products and quotients of the current operands; divisor forced non-zero so
  // the divider never sees zero (the result is discarded in that case anyway)
  always_comb begin
    a_sx_s   = {{32{A[31]}}, A};
    b_sx_s   = {{32{B[31]}}, B};
    prod_s_s = a_sx_s * b_sx_s;
    prod_u_s = {32'd0, A} * {32'd0, B};
`ifdef MDU_MADD_EN
    acc_s    = {hi_q, lo_q};
`endif
    div_b_s  = (B == 32'd0) ? 32'd1 : B;
    uq_s     = A / div_b_s;
    ur_s     = A % div_b_s;
    // Signed divide done on magnitudes so 0x80000000 / -1 wraps cleanly
    a_mag_s  = A[31] ? (32'd0 - A) : A;
    b_mag_s  = div_b_s[31] ? (32'd0 - div_b_s) : div_b_s;
    sq_mag_s = a_mag_s / b_mag_s;
    sr_mag_s = a_mag_s % b_mag_s;
    sq_s     = (A[31] ^ B[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
    sr_s     = A[31] ? (32'd0 - sr_mag_s) : sr_mag_s;
  end

  // Select the pending result, its latency and whether it will be written back
  always_comb begin
    op_valid_s   = 1'b0;
    res_wr_s     = 1'b0;
    res_hi_s     = 32'd0;
    res_lo_s     = 32'd0;
    res_cycles_s = CNT_W'(MULT_CYCLES);
    case (md_op)
      OP_MULT: begin
        op_valid_s = 1'b1;
        res_wr_s   = 1'b1;
        res_hi_s   = prod_s_s[63:32];
        res_lo_s   = prod_s_s[31:0];
      end
      OP_MULTU: begin
        op_valid_s = 1'b1;
        res_wr_s   = 1'b1;
        res_hi_s   = prod_u_s[63:32];
        res_lo_s   = prod_u_s[31:0];
      end
      OP_DIV: begin
        op_valid_s   = 1'b1;
        res_wr_s     = (B != 32'd0);
        res_hi_s     = sr_s;
        res_lo_s     = sq_s;
        res_cycles_s = CNT_W'(DIV_CYCLES);
      end
      OP_DIVU: begin
        op_valid_s   = 1'b1;
        res_wr_s     = (B != 32'd0);
        res_hi_s     = ur_s;
        res_lo_s     = uq_s;
        res_cycles_s = CNT_W'(DIV_CYCLES);
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        op_valid_s = 1'b1;
        res_wr_s   = 1'b1;
        {res_hi_s, res_lo_s} = acc_s + prod_s_s;
      end
      OP_MADDU: begin
        op_valid_s = 1'b1;
        res_wr_s   = 1'b1;
        {res_hi_s, res_lo_s} = acc_s + prod_u_s;
      end
      OP_MSUB: begin
        op_valid_s = 1'b1;
        res_wr_s   = 1'b1;
        {res_hi_s, res_lo_s} = acc_s - prod_s_s;
      end
      OP_MSUBU: begin
        op_valid_s = 1'b1;
        res_wr_s   = 1'b1;
        {res_hi_s, res_lo_s} = acc_s - prod_u_s;
      end
`endif
      default: begin
        op_valid_s = 1'b0;
      end
    endcase
  end

  // Issue qualifier: a flushed instruction or an unsupported op never starts
  assign issue_s = start & ~Interrupt & op_valid_s;

  // Next-state logic for the busy FSM, HI/LO and pending result registers
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_s) begin
          state_d   = ST_BUSY;
          count_d   = res_cycles_s;
          pend_hi_d = res_hi_s;
          pend_lo_d = res_lo_s;
          pend_wr_d = res_wr_s;
        end else if (!Interrupt && (md_op == OP_MTHI)) begin
          hi_d = A;
        end else if (!Interrupt && (md_op == OP_MTLO)) begin
          lo_d = A;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (count_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          count_d = '0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset; reset also aborts an op in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy   = (state_q == ST_BUSY);
  assign HI_out = hi_q;
  assign LO_out = lo_q;

  // MFHI/MFLO read port for the E-stage result mux
  always_comb begin
    case (md_op)
      OP_MFHI: MD_out = hi_q;
      OP_MFLO: MD_out = lo_q;
      default: MD_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed test of e_mdu. A cycle-level behavioural model
// (plain 64-bit integer arithmetic and a completion-cycle timestamp) is
// compared against the DUT on every falling edge. Directed checks with
// hand-computed values also pin the model.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        Interrupt;
  logic [3:0]  md_op;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI_out;
  logic [31:0] LO_out;
  logic [31:0] MD_out;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  e_mdu dut (
    .clk       (clk),
    .reset     (reset),
    .Interrupt (Interrupt),
    .md_op     (md_op),
    .start     (start),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .HI_out    (HI_out),
    .LO_out    (LO_out),
    .MD_out    (MD_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] m_phi = 32'd0;
  logic [31:0] m_plo = 32'd0;
  bit          m_pwr = 1'b0;
  int          cyc = 0;
  int          done_at = 0;

  function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] hi, input logic [31:0] lo,
                                   output bit ok, output bit wr, output logic [31:0] nh,
                                   output logic [31:0] nl, output int nc);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] p, acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    acc = {hi, lo};
    ok = 1'b1; wr = 1'b1; nc = 5; p = 64'd0;
    case (op)
      4'd1: p = sa * sb;
      4'd2: p = ua * ub;
      4'd3: begin
        nc = 10;
        if (b == 32'd0) wr = 1'b0;
        else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
      end
      4'd4: begin
        nc = 10;
        if (b == 32'd0) wr = 1'b0;
        else begin uq = ua / ub; ur = ua % ub; p = {ur[31:0], uq[31:0]}; end
      end
`ifdef MDU_MADD_EN
      4'd9:  p = acc + 64'(sa * sb);
      4'd10: p = acc + 64'(ua * ub);
      4'd11: p = acc - 64'(sa * sb);
      4'd12: p = acc - 64'(ua * ub);
`endif
      default: ok = 1'b0;
    endcase
    nh = p[63:32];
    nl = p[31:0];
  endfunction

  // Model update: each rising edge applies the architectural rules
  always @(posedge clk) begin
    bit wb, ok, wr;
    logic [31:0] nh, nl;
    int nc;
    wb = (cyc < done_at);
    cyc++;
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; done_at = 0;
    end else if (wb) begin
      if (cyc == done_at && m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (!Interrupt) begin
      model_op(md_op, A, B, m_hi, m_lo, ok, wr, nh, nl, nc);
      if (start && ok) begin
        m_phi = nh; m_plo = nl; m_pwr = wr; done_at = cyc + nc;
      end else if (md_op == 4'd7) m_hi = A;
      else if (md_op == 4'd8) m_lo = A;
    end
  end

  // Compare process: DUT against model on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_busy", {31'd0, busy}, {31'd0, (cyc < done_at)});
      chk("cmp_hi", HI_out, m_hi);
      chk("cmp_lo", LO_out, m_lo);
      chk("cmp_md", MD_out, (md_op == 4'd5) ? m_hi : ((md_op == 4'd6) ? m_lo : 32'd0));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic st, input logic irq);
    md_op = op; A = a; B = b; start = st; Interrupt = irq;
    step();
    md_op = 4'd0; start = 1'b0; Interrupt = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; Interrupt = 1'b0; md_op = 4'd0; start = 1'b0; A = 32'd0; B = 32'd0;
    step(); step();
    chk_en = 1'b1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI_out, 32'd0);
    chk("rst_lo", LO_out, 32'd0);
    reset = 1'b0;

    // reset in the middle of a multiply
    drive(4'd8, 32'h55, 32'd0, 1'b0, 1'b0);
    chk("mtlo_55", LO_out, 32'h55);
    drive(4'd1, 32'd3, 32'd4, 1'b1, 1'b0);
    chk("mult_busy", {31'd0, busy}, 32'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_lo", LO_out, 32'd0);
    repeat (8) step();
    chk("abort_stay_busy", {31'd0, busy}, 32'd0);
    chk("abort_stay_lo", LO_out, 32'd0);

    // multiply
    drive(4'd1, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
    wait_idle(n);
    chk("mult_cycles", n, 32'd5);
    chk("mult_hi", HI_out, 32'hFFFFFFFF);
    chk("mult_lo", LO_out, 32'hFFFFFFFE);
    drive(4'd2, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
    wait_idle(n);
    chk("multu_cycles", n, 32'd5);
    chk("multu_hi", HI_out, 32'd1);
    chk("multu_lo", LO_out, 32'hFFFFFFFE);

    // divide
    drive(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
    wait_idle(n);
    chk("div_cycles", n, 32'd10);
    chk("div_lo", LO_out, 32'hFFFFFFFD);
    chk("div_hi", HI_out, 32'hFFFFFFFF);
    drive(4'd4, 32'd7, 32'd0, 1'b1, 1'b0);
    wait_idle(n);
    chk("divz_cycles", n, 32'd10);
    chk("divz_hi", HI_out, 32'hFFFFFFFF);
    chk("divz_lo", LO_out, 32'hFFFFFFFD);
    drive(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
    wait_idle(n);
    chk("divovf_lo", LO_out, 32'h80000000);
    chk("divovf_hi", HI_out, 32'd0);
    drive(4'd3, 32'd7, 32'hFFFFFFFE, 1'b1, 1'b0);
    wait_idle(n);
    chk("divneg_lo", LO_out, 32'hFFFFFFFD);
    chk("divneg_hi", HI_out, 32'd1);
    drive(4'd4, 32'd100, 32'd7, 1'b1, 1'b0);
    wait_idle(n);
    chk("divu_lo", LO_out, 32'd14);
    chk("divu_hi", HI_out, 32'd2);

    // MTHI under interrupt, then MFHI/MFLO
    drive(4'd7, 32'h1234, 32'd0, 1'b0, 1'b1);
    chk("mthi_irq_hi", HI_out, 32'd2);
    drive(4'd7, 32'h1234, 32'd0, 1'b0, 1'b0);
    chk("mthi_hi", HI_out, 32'h1234);
    md_op = 4'd5; #1;
    chk("mfhi", MD_out, 32'h1234);
    md_op = 4'd6; #1;
    chk("mflo", MD_out, 32'd14);
    md_op = 4'd0; #1;
    chk("md_none", MD_out, 32'd0);

    // interrupt while busy, interrupt on start, MTLO while busy, unused op
    drive(4'd1, 32'd6, 32'd7, 1'b1, 1'b0);
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    wait_idle(n);
    chk("irq_busy_cycles", n, 32'd4);
    chk("irq_busy_lo", LO_out, 32'd42);
    chk("irq_busy_hi", HI_out, 32'd0);
    drive(4'd1, 32'd5, 32'd5, 1'b1, 1'b1);
    chk("irq_start_busy", {31'd0, busy}, 32'd0);
    chk("irq_start_lo", LO_out, 32'd42);
    drive(4'd1, 32'd3, 32'd3, 1'b1, 1'b0);
    drive(4'd8, 32'hDEAD, 32'd0, 1'b0, 1'b0);
    wait_idle(n);
    chk("mtlo_busy_lo", LO_out, 32'd9);
    drive(4'd13, 32'd1, 32'd1, 1'b1, 1'b0);
    chk("op13_busy", {31'd0, busy}, 32'd0);

    // multiply-accumulate
    drive(4'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(4'd8, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0);
    drive(4'd10, 32'd1, 32'd1, 1'b1, 1'b0);
`ifdef MDU_MADD_EN
    wait_idle(n);
    chk("maddu_cycles", n, 32'd5);
    chk("maddu_hi", HI_out, 32'd1);
    chk("maddu_lo", LO_out, 32'd0);
    drive(4'd11, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0);
    wait_idle(n);
    chk("msub_hi", HI_out, 32'd1);
    chk("msub_lo", LO_out, 32'd1);
`else
    chk("maddu_off_busy", {31'd0, busy}, 32'd0);
    repeat (6) step();
    chk("maddu_off_hi", HI_out, 32'd0);
    chk("maddu_off_lo", LO_out, 32'hFFFFFFFF);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
